// File: rtl/pc_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pc_seq_pkg                                                       |
// | Purpose : Shared constants for the next-PC sequencer: FSM state encoding,  |
// |           target-generator select codes and parameter defaults.            |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package pc_seq_pkg;

  localparam int ADDR_W_DEF    = 6;
  localparam int RESET_VEC_DEF = 0;

  // FSM state encoding; also visible on the state_o debug port
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RUN      = 3'd1;
  localparam logic [2:0] ST_STALL    = 3'd2;
  localparam logic [2:0] ST_REDIRECT = 3'd3;
  localparam logic [2:0] ST_HALT     = 3'd4;

  // Target generator select
  localparam logic [1:0] SEL_HOLD   = 2'd0;
  localparam logic [1:0] SEL_INC    = 2'd1;
  localparam logic [1:0] SEL_BRANCH = 2'd2;
  localparam logic [1:0] SEL_JUMP   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_target_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pc_target_gen                                                    |
// | Purpose : Combinational next-PC candidate mux: hold, increment, relative   |
// |           branch target (pc+1+offset) or absolute jump target.             |
// | Ports   : pc_cur     in  current PC                                        |
// |           branch_off in  signed word offset relative to pc_cur+1           |
// |           jump_tgt   in  absolute jump target                              |
// |           sel        in  SEL_HOLD / SEL_INC / SEL_BRANCH / SEL_JUMP        |
// |           target     out selected next PC                                  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pc_target_gen
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic [ADDR_W-1:0] branch_off,
  input  logic [ADDR_W-1:0] jump_tgt,
  input  logic [1:0]        sel,
  output logic [ADDR_W-1:0] target
);

  logic [ADDR_W-1:0] w_pc_inc;

  // Same-width addition wraps modulo 2**ADDR_W, which also makes the
  // two's-complement offset behave as a sign-extended value.
  assign w_pc_inc = pc_cur + ADDR_W'(1);

  always_comb begin
    target = pc_cur;
    case (sel)
      SEL_INC:    target = w_pc_inc;
      SEL_BRANCH: target = w_pc_inc + branch_off;
      SEL_JUMP:   target = jump_tgt;
      default:    target = pc_cur;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pc_sequencer                                                     |
// | Purpose : Next-PC controller. Drives the PC register input every cycle and |
// |           sequences fetch through IDLE/RUN/STALL/REDIRECT/HALT.            |
// | Ports   : CLK, RST (sync, active high)                                     |
// |           start, stall, branch_taken, branch_off, jump, jump_tgt,          |
// |           halt_req                              request inputs             |
// |           pc_cur       in  PC register output                              |
// |           pc_next      out PC register input (combinational)               |
// |           fetch_valid  out instruction fetched at pc_cur is valid          |
// |           flush        out kill wrong-path instructions in IF/ID           |
// |           halted       out registered, high in HALT                        |
// |           state_o      out registered FSM state                            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RESET_VEC = RESET_VEC_DEF,
  parameter int FLUSH_CYC = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_off,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_tgt,
  input  logic              halt_req,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic [ADDR_W-1:0] pc_next,
  output logic              fetch_valid,
  output logic              flush,
  output logic              halted,
  output logic [2:0]        state_o
);

  localparam logic [ADDR_W-1:0] C_RESET_PC   = ADDR_W'(RESET_VEC);
  localparam logic [1:0]        C_FLUSH_LAST = 2'(FLUSH_CYC - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [1:0]        r_flush_cnt;
  logic              r_halted;
  logic [1:0]        w_sel;
  logic [ADDR_W-1:0] w_target;
  logic              w_redir_done;

  // Counter is cleared in every non-REDIRECT cycle, so it is always zero on
  // the first REDIRECT cycle.
  assign w_redir_done = (r_flush_cnt == C_FLUSH_LAST);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= 2'd0;
      r_halted    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_halted <= (w_state_nxt == ST_HALT);
      if (r_state == ST_REDIRECT) begin
        r_flush_cnt <= r_flush_cnt + 2'd1;
      end else begin
        r_flush_cnt <= 2'd0;
      end
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN, ST_STALL: begin
        if (halt_req)                 w_state_nxt = ST_HALT;
        else if (jump || branch_taken) w_state_nxt = ST_REDIRECT;
        else if (stall)               w_state_nxt = ST_STALL;
        else                          w_state_nxt = ST_RUN;
      end
      ST_REDIRECT: begin
        // Only halt_req can cut a redirect short
        if (halt_req)          w_state_nxt = ST_HALT;
        else if (w_redir_done) w_state_nxt = ST_RUN;
      end
      ST_HALT:  w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------ output decode
  always_comb begin
    w_sel       = SEL_HOLD;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    case (r_state)
      ST_RUN, ST_STALL: begin
        if (halt_req) begin
          w_sel = SEL_HOLD;
        end else if (jump) begin
          w_sel = SEL_JUMP;
          flush = 1'b1;
        end else if (branch_taken) begin
          w_sel = SEL_BRANCH;
          flush = 1'b1;
        end else if (stall) begin
          w_sel = SEL_HOLD;
        end else begin
          // Also the stall-exit cycle: the held instruction issues now
          w_sel       = SEL_INC;
          fetch_valid = 1'b1;
        end
      end
      ST_REDIRECT: flush = 1'b1;
      default: ;
    endcase
    if (RST) begin
      fetch_valid = 1'b0;
      flush       = 1'b0;
    end
  end

  pc_target_gen #(
    .ADDR_W (ADDR_W)
  ) u_target_gen (
    .pc_cur     (pc_cur),
    .branch_off (branch_off),
    .jump_tgt   (jump_tgt),
    .sel        (w_sel),
    .target     (w_target)
  );

  // The PC register loads every edge, so reset must be forced onto its input
  assign pc_next = RST ? C_RESET_PC : w_target;
  assign halted  = r_halted;
  assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pc_sequencer                                                  |
// | Purpose : Self-checking bench for pc_sequencer. Holds the PC register      |
// |           itself, runs directed scenarios and a randomized phase against a |
// |           behavioural reference model.                                     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_pc_sequencer;

  localparam int AW    = 6;
  localparam int FLUSH = 2;

  // Architectural state numbers visible on state_o
  localparam logic [2:0] M_IDLE = 3'd0, M_RUN = 3'd1, M_STALL = 3'd2,
                         M_REDIR = 3'd3, M_HALT = 3'd4;

  logic          CLK, RST, start, stall, branch_taken, jump, halt_req;
  logic [AW-1:0] branch_off, jump_tgt, pc_reg, pc_next;
  logic          fetch_valid, flush, halted;
  logic [2:0]    state_o;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Reference model state and per-cycle expectations
  logic [2:0]    m_mode = M_IDLE;
  int            m_left = 0;
  logic [AW-1:0] e_pc;
  logic          e_fv, e_fl;
  logic [2:0]    e_mode_nxt;
  int            e_left_nxt;

  pc_sequencer #(.ADDR_W(AW), .RESET_VEC(0), .FLUSH_CYC(FLUSH)) dut (
    .CLK(CLK), .RST(RST), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_off(branch_off),
    .jump(jump), .jump_tgt(jump_tgt), .halt_req(halt_req),
    .pc_cur(pc_reg), .pc_next(pc_next), .fetch_valid(fetch_valid),
    .flush(flush), .halted(halted), .state_o(state_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Behaviour from the rules: priority list, modular arithmetic, countdown of
  // remaining redirect bubbles.
  task automatic model_eval();
    int off, t;
    e_fv = 1'b0; e_fl = 1'b0; e_pc = pc_reg;
    e_mode_nxt = m_mode; e_left_nxt = m_left;
    if (RST) begin
      e_pc = 6'd0; e_mode_nxt = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (start) e_mode_nxt = M_RUN;
    end else if (m_mode == M_RUN || m_mode == M_STALL) begin
      if (halt_req) begin
        e_mode_nxt = M_HALT;
      end else if (jump) begin
        e_pc = jump_tgt; e_fl = 1'b1; e_mode_nxt = M_REDIR; e_left_nxt = FLUSH;
      end else if (branch_taken) begin
        off = (int'(branch_off) >= 32) ? int'(branch_off) - 64 : int'(branch_off);
        t = int'(pc_reg) + 1 + off;
        e_pc = 6'(((t % 64) + 64) % 64);
        e_fl = 1'b1; e_mode_nxt = M_REDIR; e_left_nxt = FLUSH;
      end else if (stall) begin
        e_mode_nxt = M_STALL;
      end else begin
        e_pc = 6'((int'(pc_reg) + 1) % 64); e_fv = 1'b1; e_mode_nxt = M_RUN;
      end
    end else if (m_mode == M_REDIR) begin
      e_fl = 1'b1;
      if (halt_req) begin
        e_mode_nxt = M_HALT;
      end else begin
        e_left_nxt = m_left - 1;
        if (e_left_nxt == 0) e_mode_nxt = M_RUN;
      end
    end
  endtask

  // One clock: PC register loads pc_next, model commits. Ends 1 unit after edge.
  task automatic tick();
    logic [AW-1:0] nxt;
    model_eval();
    nxt = pc_next;
    @(posedge CLK);
    pc_reg = nxt;
    m_mode = e_mode_nxt;
    m_left = e_left_nxt;
    #1;
  endtask

  task automatic clear_req();
    start = 0; stall = 0; branch_taken = 0; jump = 0; halt_req = 0;
    branch_off = '0; jump_tgt = '0;
  endtask

  task automatic test_reset();
    clear_req();
    RST = 1; pc_reg = 'x;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      cmp_cnt++;
      if ({pc_next, fetch_valid, flush} !== {6'd0, 1'b0, 1'b0}) begin
        err_cnt++; $display("FAIL reset_outputs: got pc_next=%0d fv=%b flush=%b want 0/0/0", pc_next, fetch_valid, flush);
      end
      tick();
    end
    RST = 0;
    @(negedge CLK);
    cmp_cnt++;
    if ({state_o, halted, pc_next, fetch_valid} !== {M_IDLE, 1'b0, 6'd0, 1'b0}) begin
      err_cnt++; $display("FAIL reset_idle: got state=%0d halted=%b pc_next=%0d fv=%b want 0/0/0/0", state_o, halted, pc_next, fetch_valid);
    end
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      cmp_cnt++;
      if ({pc_reg, pc_next, fetch_valid, state_o} !== {6'(i), 6'(i + 1), 1'b1, M_RUN}) begin
        err_cnt++; $display("FAIL count_%0d: got pc=%0d pc_next=%0d fv=%b state=%0d want %0d/%0d/1/1", i, pc_reg, pc_next, fetch_valid, state_o, i, i + 1);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_seq [5];
    exp_seq = '{6'd61, 6'd62, 6'd63, 6'd0, 6'd1};
    pc_reg = 6'd60;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      cmp_cnt++;
      if ({pc_next, fetch_valid} !== {exp_seq[i], 1'b1}) begin
        err_cnt++; $display("FAIL wrap_%0d: got pc_next=%0d fv=%b want %0d/1", i, pc_next, fetch_valid, exp_seq[i]);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    pc_reg = 6'd2; branch_taken = 1; branch_off = 6'b111011;  // -5
    @(negedge CLK);
    cmp_cnt++;
    if ({pc_next, flush, fetch_valid} !== {6'd62, 1'b1, 1'b0}) begin
      err_cnt++; $display("FAIL branch_target: got pc_next=%0d flush=%b fv=%b want 62/1/0", pc_next, flush, fetch_valid);
    end
    tick();
    clear_req();
    for (int i = 0; i < FLUSH; i++) begin
      @(negedge CLK);
      cmp_cnt++;
      if ({pc_next, flush, fetch_valid, state_o} !== {6'd62, 1'b1, 1'b0, M_REDIR}) begin
        err_cnt++; $display("FAIL branch_bubble_%0d: got pc_next=%0d flush=%b fv=%b state=%0d want 62/1/0/3", i, pc_next, flush, fetch_valid, state_o);
      end
      tick();
    end
    @(negedge CLK);
    cmp_cnt++;
    if ({pc_next, flush, fetch_valid, state_o} !== {6'd63, 1'b0, 1'b1, M_RUN}) begin
      err_cnt++; $display("FAIL branch_resume: got pc_next=%0d flush=%b fv=%b state=%0d want 63/0/1/1", pc_next, flush, fetch_valid, state_o);
    end
    tick();
    @(negedge CLK);
    cmp_cnt++;
    if (pc_next !== 6'd0) begin
      err_cnt++; $display("FAIL branch_after_wrap: got pc_next=%0d want 0", pc_next);
    end
    tick();
    jump = 1; jump_tgt = 6'd40; branch_taken = 1; branch_off = 6'd7;
    @(negedge CLK);
    cmp_cnt++;
    if ({pc_next, flush} !== {6'd40, 1'b1}) begin
      err_cnt++; $display("FAIL jump_beats_branch: got pc_next=%0d flush=%b want 40/1", pc_next, flush);
    end
    tick();
    clear_req();
    for (int i = 0; i < FLUSH; i++) tick();
    @(negedge CLK);
    cmp_cnt++;
    if ({pc_next, state_o} !== {6'd41, M_RUN}) begin
      err_cnt++; $display("FAIL jump_resume: got pc_next=%0d state=%0d want 41/1", pc_next, state_o);
    end
    tick();
  endtask

  task automatic test_stall();
    pc_reg = 6'd10; stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      cmp_cnt++;
      if ({pc_next, fetch_valid} !== {6'd10, 1'b0}) begin
        err_cnt++; $display("FAIL stall_hold_%0d: got pc_next=%0d fv=%b want 10/0", i, pc_next, fetch_valid);
      end
      tick();
    end
    stall = 0;
    @(negedge CLK);
    cmp_cnt++;
    if ({pc_next, fetch_valid, state_o} !== {6'd11, 1'b1, M_STALL}) begin
      err_cnt++; $display("FAIL stall_release: got pc_next=%0d fv=%b state=%0d want 11/1/2", pc_next, fetch_valid, state_o);
    end
    tick();
    stall = 1;
    tick();
    jump = 1; jump_tgt = 6'd20;
    @(negedge CLK);
    cmp_cnt++;
    if ({pc_next, flush, fetch_valid} !== {6'd20, 1'b1, 1'b0}) begin
      err_cnt++; $display("FAIL stall_jump: got pc_next=%0d flush=%b fv=%b want 20/1/0", pc_next, flush, fetch_valid);
    end
    tick();
    clear_req();
    for (int i = 0; i < FLUSH; i++) tick();
  endtask

  task automatic test_halt_reset();
    pc_reg = 6'd7; halt_req = 1;
    @(negedge CLK);
    cmp_cnt++;
    if ({pc_next, fetch_valid} !== {6'd7, 1'b0}) begin
      err_cnt++; $display("FAIL halt_entry: got pc_next=%0d fv=%b want 7/0", pc_next, fetch_valid);
    end
    tick();
    halt_req = 0; start = 1; jump = 1; jump_tgt = 6'd33; branch_taken = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      cmp_cnt++;
      if ({pc_next, halted, state_o, fetch_valid, flush} !== {6'd7, 1'b1, M_HALT, 1'b0, 1'b0}) begin
        err_cnt++; $display("FAIL halt_hold_%0d: got pc_next=%0d halted=%b state=%0d fv=%b flush=%b want 7/1/4/0/0", i, pc_next, halted, state_o, fetch_valid, flush);
      end
      tick();
    end
    clear_req();
    RST = 1;
    tick();
    RST = 0; start = 1;
    tick();
    start = 0; jump = 1; jump_tgt = 6'd25;
    tick();
    jump = 0; RST = 1;
    @(negedge CLK);
    cmp_cnt++;
    if ({state_o, pc_next, flush, fetch_valid} !== {M_REDIR, 6'd0, 1'b0, 1'b0}) begin
      err_cnt++; $display("FAIL rst_in_redirect: got state=%0d pc_next=%0d flush=%b fv=%b want 3/0/0/0", state_o, pc_next, flush, fetch_valid);
    end
    tick();
    RST = 0;
    @(negedge CLK);
    cmp_cnt++;
    if ({state_o, flush, pc_reg, halted} !== {M_IDLE, 1'b0, 6'd0, 1'b0}) begin
      err_cnt++; $display("FAIL rst_after_redirect: got state=%0d flush=%b pc=%0d halted=%b want 0/0/0/0", state_o, flush, pc_reg, halted);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      RST          = ($urandom_range(0, 39) == 0);
      start        = ($urandom_range(0, 1) == 0);
      halt_req     = ($urandom_range(0, 39) == 0);
      jump         = ($urandom_range(0, 7) == 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      branch_off   = 6'($urandom);
      jump_tgt     = 6'($urandom);
      @(negedge CLK);
      model_eval();
      cmp_cnt++;
      if ({pc_next, fetch_valid, flush, state_o, halted} !==
          {e_pc, e_fv, e_fl, m_mode, (m_mode == M_HALT)}) begin
        err_cnt++;
        $display("FAIL random_%0d: got pc_next=%0d fv=%b flush=%b state=%0d halted=%b want %0d/%b/%b/%0d/%b",
                 i, pc_next, fetch_valid, flush, state_o, halted, e_pc, e_fv, e_fl, m_mode, (m_mode == M_HALT));
      end
      tick();
    end
    clear_req();
    RST = 0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_branch();
    test_stall();
    test_halt_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
